// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit arbiter: FSM encodings, byte width
// and the default launch watchdog length.
package uart_pkg;

    localparam int BYTE_W            = 8;
    localparam int START_TIMEOUT_DEF = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_LAUNCH = 2'd1;
    localparam state_t ST_BUSY   = 2'd2;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin select: first set request bit at or above rr_ptr,
// wrapping modulo N_REQ.
module rr_picker #(
    parameter  int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [IDX_W-1:0] winner,
    output logic             any_req
);

    int idx;

    // Scan offsets from farthest to nearest so the nearest pending requester wins.
    always_comb begin
        winner  = {IDX_W{1'b0}};
        any_req = 1'b0;
        idx     = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end else begin
                idx = idx;
            end
            if (req[idx]) begin
                winner  = idx[IDX_W-1:0];
                any_req = 1'b1;
            end else begin
                any_req = any_req;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of the shared UART transmitter: grants one requester,
// launches its byte, tracks the frame and aborts launches that never start.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int N_REQ         = 4,
    parameter  int START_TIMEOUT = START_TIMEOUT_DEF,
    localparam int IDX_W         = $clog2(N_REQ)
) (
    input  logic                    baud_clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*BYTE_W-1:0] req_data,
    output logic [N_REQ-1:0]        grant,
    output logic                    tx_send,
    output logic [BYTE_W-1:0]       tx_data,
    input  logic                    tx_active,
    input  logic                    tx_done,
    output logic                    busy,
    output logic [IDX_W-1:0]        owner,
    output logic                    frame_done,
    output logic                    err_timeout
);

    localparam int CNT_W = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
    logic [N_REQ-1:0]    grant_q, grant_d;
    logic                tx_send_q, tx_send_d;
    logic                busy_q, busy_d;
    logic                frame_done_q, frame_done_d;
    logic                err_timeout_q, err_timeout_d;
    logic [CNT_W-1:0]    to_cnt_q, to_cnt_d;

    logic [IDX_W-1:0]    winner_s;
    logic                any_req_s;
    logic [IDX_W-1:0]    owner_inc_s;

    rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req     (req),
        .rr_ptr  (rr_ptr_q),
        .winner  (winner_s),
        .any_req (any_req_s)
    );

    // Pointer value that hands priority to the requester after the current owner.
    always_comb begin
        if (owner_q == IDX_W'(N_REQ - 1)) begin
            owner_inc_s = {IDX_W{1'b0}};
        end else begin
            owner_inc_s = owner_q + IDX_W'(1);
        end
    end

    // Next-state logic: grant/capture in IDLE, watchdog in LAUNCH, completion in BUSY.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        owner_d       = owner_q;
        tx_data_d     = tx_data_q;
        grant_d       = {N_REQ{1'b0}};
        tx_send_d     = 1'b0;
        frame_done_d  = 1'b0;
        err_timeout_d = 1'b0;
        to_cnt_d      = to_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_d   = ST_LAUNCH;
                    owner_d   = winner_s;
                    tx_data_d = req_data[winner_s*BYTE_W +: BYTE_W];
                    grant_d   = {{(N_REQ-1){1'b0}}, 1'b1} << winner_s;
                    tx_send_d = 1'b1;
                    to_cnt_d  = {CNT_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                if (tx_active) begin
                    state_d = ST_BUSY;
                end else if (to_cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
                    // Transmitter never picked the byte up: give the next requester a turn.
                    err_timeout_d = 1'b1;
                    rr_ptr_d      = owner_inc_s;
                    state_d       = ST_IDLE;
                end else begin
                    to_cnt_d  = to_cnt_q + CNT_W'(1);
                    tx_send_d = 1'b1;
                end
            end
            ST_BUSY: begin
                if (!tx_active && tx_done) begin
                    frame_done_d = 1'b1;
                    rr_ptr_d     = owner_inc_s;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge baud_clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= {IDX_W{1'b0}};
            owner_q       <= {IDX_W{1'b0}};
            tx_data_q     <= {BYTE_W{1'b0}};
            grant_q       <= {N_REQ{1'b0}};
            tx_send_q     <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            err_timeout_q <= 1'b0;
            to_cnt_q      <= {CNT_W{1'b0}};
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            owner_q       <= owner_d;
            tx_data_q     <= tx_data_d;
            grant_q       <= grant_d;
            tx_send_q     <= tx_send_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            err_timeout_q <= err_timeout_d;
            to_cnt_q      <= to_cnt_d;
        end
    end

    assign grant       = grant_q;
    assign tx_send     = tx_send_q;
    assign tx_data     = tx_data_q;
    assign busy        = busy_q;
    assign owner       = owner_q;
    assign frame_done  = frame_done_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a behavioural UART transmitter
// model and grant/frame scoreboards.
module tb_uart_tx_arbiter;

    logic        baud_clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = 4'b0000;
    logic [31:0] req_data = 32'h0;
    logic [3:0]  grant;
    logic        tx_send;
    logic [7:0]  tx_data;
    logic        tx_active = 1'b0;
    logic        tx_done = 1'b0;
    logic        busy;
    logic [1:0]  owner;
    logic        frame_done;
    logic        err_timeout;

    uart_tx_arbiter #(.N_REQ(4), .START_TIMEOUT(4)) dut (
        .baud_clk    (baud_clk),
        .reset       (reset),
        .req         (req),
        .req_data    (req_data),
        .grant       (grant),
        .tx_send     (tx_send),
        .tx_data     (tx_data),
        .tx_active   (tx_active),
        .tx_done     (tx_done),
        .busy        (busy),
        .owner       (owner),
        .frame_done  (frame_done),
        .err_timeout (err_timeout)
    );

    always #5 baud_clk = ~baud_clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int t_cyc    = 0;
    int n_grants = 0;
    logic mon_on = 1'b0;

    typedef struct { logic [1:0] own; logic [7:0] b; } frm_t;
    int   exp_grant_q[$];
    frm_t exp_frame_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge baud_clk) cyc <= cyc + 1;

    // Transmitter model: samples send, raises active 2 cycles later for 11 bit times.
    logic       m_en = 1'b0;
    int         m_st = 0;
    int         m_w = 0;
    int         m_bitn = 0;
    logic [7:0] m_byte = 8'h00;
    logic       ser_line;
    logic [7:0] rx_sr = 8'h00;
    logic [7:0] rx_byte = 8'h00;

    always @(posedge baud_clk) begin
        tx_done <= 1'b0;
        case (m_st)
            0: if (m_en && tx_send) begin m_st <= 1; m_w <= 0; m_byte <= tx_data; end
            1: if (m_w == 1) begin m_st <= 2; tx_active <= 1'b1; m_bitn <= 0; end
               else m_w <= m_w + 1;
            2: if (m_bitn == 10) begin tx_active <= 1'b0; tx_done <= 1'b1; m_st <= 0; end
               else m_bitn <= m_bitn + 1;
            default: m_st <= 0;
        endcase
    end

    always_comb begin
        ser_line = 1'b1;
        if (tx_active && m_bitn == 0) ser_line = 1'b0;
        else if (tx_active && m_bitn >= 1 && m_bitn <= 8) ser_line = m_byte[m_bitn-1];
    end

    // Serial receiver: rebuilds the byte from the line, independent of tx_data.
    always @(negedge baud_clk) begin
        if (tx_active && m_bitn >= 1 && m_bitn <= 8) rx_sr[m_bitn-1] <= ser_line;
        if (tx_done) rx_byte <= rx_sr;
    end

    // Monitor: grant and frame scoreboards, send-length and exclusivity checks.
    initial begin
        int run;
        run = 0;
        forever begin
            @(negedge baud_clk);
            if (mon_on) begin
                if (grant != 4'b0000) begin
                    n_grants++;
                    if (exp_grant_q.size() == 0) begin
                        chk("unexpected_grant", 32'(grant), 32'h0);
                    end else begin
                        int g;
                        logic [3:0] one;
                        g = exp_grant_q.pop_front();
                        one = 4'b0001 << g;
                        chk("grant", 32'(grant), 32'(one));
                        chk("grant_owner", 32'(owner), 32'(g));
                    end
                end
                if (frame_done) begin
                    if (exp_frame_q.size() == 0) begin
                        chk("unexpected_frame_done", 32'(frame_done), 32'h0);
                    end else begin
                        frm_t f;
                        f = exp_frame_q.pop_front();
                        chk("frame_owner", 32'(owner), 32'(f.own));
                        chk("frame_serial_byte", 32'(rx_byte), 32'(f.b));
                    end
                end
                if (frame_done && err_timeout) chk("fd_err_exclusive", 32'h1, 32'h0);
                if (tx_send) run++;
                else begin
                    if (run > 4) chk("tx_send_len", 32'(run), 32'h4);
                    run = 0;
                end
            end
        end
    end

    task automatic wait_for(input int which, input int budget, input string nm);
        int n;
        logic hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < budget) begin
            @(negedge baud_clk);
            n++;
            case (which)
                0: hit = |grant;
                1: hit = frame_done;
                2: hit = err_timeout;
                3: hit = (m_st == 0);
                4: hit = !tx_send;
                default: hit = 1'b1;
            endcase
        end
        if (!hit) chk({nm, "_wait_expired"}, 32'h0, 32'h1);
        t_cyc = cyc;
    endtask

    task automatic do_reset();
        @(negedge baud_clk);
        reset = 1'b1;
        req = 4'b0000;
        @(negedge baud_clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  grant;
        int          own;
        logic [7:0]  b;
    } vec_t;
    vec_t vecs[6];

    initial begin
        int g_cyc;
        int fd_cyc;
        int ng;
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int g_cyc;
        int fd_cyc;
        int ng;
        vecs[0] = '{4'b0001, 32'h44332211, 4'b0001, 0, 8'h11};
        vecs[1] = '{4'b0010, 32'h44332211, 4'b0010, 1, 8'h22};
        vecs[2] = '{4'b1100, 32'h44332211, 4'b0100, 2, 8'h33};
        vecs[3] = '{4'b1010, 32'hDEADBEEF, 4'b0010, 1, 8'hBE};
        vecs[4] = '{4'b1000, 32'h80000000, 4'b1000, 3, 8'h80};
        vecs[5] = '{4'b0000, 32'h12345678, 4'b0000, 0, 8'h00};

        repeat (3) @(negedge baud_clk);
        reset = 1'b0;
        mon_on = 1'b1;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_tx_send", 32'(tx_send), 32'h0);
        chk("rst_tx_data", 32'(tx_data), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_owner", 32'(owner), 32'h0);
        chk("rst_frame_done", 32'(frame_done), 32'h0);
        chk("rst_err_timeout", 32'(err_timeout), 32'h0);

        // Table: first grant from a fresh reset (pointer at 0).
        for (int i = 0; i < 6; i++) begin
            do_reset();
            req = vecs[i].req;
            req_data = vecs[i].data;
            if (vecs[i].grant != 4'b0000) exp_grant_q.push_back(vecs[i].own);
            @(negedge baud_clk);
            chk("vec_grant", 32'(grant), 32'(vecs[i].grant));
            chk("vec_owner", 32'(owner), 32'(vecs[i].own));
            chk("vec_tx_data", 32'(tx_data), 32'(vecs[i].b));
            chk("vec_busy", 32'(busy), 32'(vecs[i].grant != 4'b0000));
            chk("vec_tx_send", 32'(tx_send), 32'(vecs[i].grant != 4'b0000));
            req = 4'b0000;
            @(negedge baud_clk);
            chk("vec_grant_pulse", 32'(grant), 32'h0);
            chk("vec_tx_send_hold", 32'(tx_send), 32'(vecs[i].grant != 4'b0000));
        end

        // Single requester with a live transmitter: 15-cycle grant to frame_done.
        do_reset();
        m_en = 1'b1;
        req = 4'b0100;
        req_data = 32'h00A50000;
        exp_grant_q.push_back(2);
        exp_frame_q.push_back('{2'd2, 8'hA5});
        wait_for(0, 5, "single_grant");
        g_cyc = t_cyc;
        chk("single_tx_data", 32'(tx_data), 32'hA5);
        req = 4'b0000;
        wait_for(1, 40, "single_done");
        chk("single_latency", 32'(t_cyc - g_cyc), 32'd15);
        @(negedge baud_clk);
        chk("tx_data_held", 32'(tx_data), 32'hA5);
        chk("idle_after_frame", 32'(busy), 32'h0);

        // Wrap-around: pointer now 3, requesters 3 and 0 pending.
        req = 4'b1001;
        req_data = 32'h9C00003E;
        exp_grant_q.push_back(3);
        exp_grant_q.push_back(0);
        exp_frame_q.push_back('{2'd3, 8'h9C});
        exp_frame_q.push_back('{2'd0, 8'h3E});
        wait_for(0, 5, "wrap_grant3");
        wait_for(1, 40, "wrap_done3");
        fd_cyc = t_cyc;
        wait_for(0, 5, "wrap_grant0");
        chk("back_to_back_gap", 32'(t_cyc - fd_cyc), 32'd1);
        req = 4'b0000;
        wait_for(1, 40, "wrap_done0");

        // Reset while BUSY: outputs return to reset values, no grant without a request.
        req = 4'b0100;
        req_data = 32'h00770000;
        exp_grant_q.push_back(2);
        wait_for(0, 5, "rst_mid_grant");
        req = 4'b0000;
        wait_for(4, 10, "rst_mid_busy");
        @(negedge baud_clk);
        reset = 1'b1;
        @(negedge baud_clk);
        reset = 1'b0;
        chk("mid_rst_grant", 32'(grant), 32'h0);
        chk("mid_rst_tx_send", 32'(tx_send), 32'h0);
        chk("mid_rst_tx_data", 32'(tx_data), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_owner", 32'(owner), 32'h0);
        chk("mid_rst_fd", 32'(frame_done), 32'h0);
        repeat (4) begin
            @(negedge baud_clk);
            chk("mid_rst_no_grant", 32'(grant), 32'h0);
        end
        wait_for(3, 30, "model_idle");

        // Fairness: all four held, grants 0,1,2,3,0.
        req = 4'b1111;
        req_data = 32'h44332211;
        for (int k = 0; k < 5; k++) begin
            exp_grant_q.push_back(k % 4);
            exp_frame_q.push_back('{2'(k % 4), 8'(8'h11 * ((k % 4) + 1))});
        end
        for (int k = 0; k < 5; k++) begin
            wait_for(0, 60, "fair_grant");
            if (k == 4) req = 4'b0000;
        end
        wait_for(1, 40, "fair_done");

        // Launch timeout: transmitter never answers.
        m_en = 1'b0;
        req = 4'b0010;
        req_data = 32'h00002200;
        exp_grant_q.push_back(1);
        wait_for(0, 5, "to_grant");
        g_cyc = t_cyc;
        chk("to_tx_send_rise", 32'(tx_send), 32'h1);
        req = 4'b0000;
        wait_for(2, 20, "to_err");
        chk("to_latency", 32'(t_cyc - g_cyc), 32'd4);
        chk("to_busy", 32'(busy), 32'h0);
        chk("to_tx_send", 32'(tx_send), 32'h0);
        @(negedge baud_clk);
        chk("to_busy_after", 32'(busy), 32'h0);
        chk("to_err_pulse", 32'(err_timeout), 32'h0);

        // Late drop: pointer now 2, so 0 wins over 1; 1 drops during BUSY.
        m_en = 1'b1;
        req = 4'b0011;
        req_data = 32'h0000C35A;
        exp_grant_q.push_back(0);
        exp_frame_q.push_back('{2'd0, 8'h5A});
        wait_for(0, 5, "late_grant");
        req = 4'b0010;
        wait_for(4, 10, "late_busy");
        req = 4'b0000;
        ng = n_grants;
        wait_for(1, 40, "late_done");
        repeat (12) @(negedge baud_clk);
        chk("late_no_regrant", 32'(n_grants), 32'(ng));
        chk("grant_q_empty", 32'(exp_grant_q.size()), 32'h0);
        chk("frame_q_empty", 32'(exp_frame_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
